// File: rtl/cache_rd_arbiter.sv
// Read-port arbiter between icache refill, dcache refill and uncached loads.
// One outstanding bridge read at a time; returned data is steered to the owner.
module cache_rd_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LINE_OFF_W   = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inst_rd_req,
  input  logic [2:0]   inst_rd_type,
  input  logic [31:0]  inst_rd_addr,
  output logic         inst_rd_rdy,
  output logic         inst_ret_valid,
  output logic [127:0] inst_ret_data,
  input  logic         data_rd_req,
  input  logic [2:0]   data_rd_type,
  input  logic [31:0]  data_rd_addr,
  input  logic [2:0]   data_rd_size,
  output logic         data_rd_rdy,
  output logic         data_ret_valid,
  output logic [127:0] data_ret_data,
  input  logic         unc_rd_req,
  input  logic [31:0]  unc_rd_addr,
  input  logic [2:0]   unc_rd_size,
  output logic         unc_rd_rdy,
  output logic         unc_ret_valid,
  output logic [31:0]  unc_ret_data,
  input  logic         wb_pending,
  input  logic [31:0]  wb_addr,
  output logic         mem_rd_req,
  output logic [2:0]   mem_rd_type,
  output logic [31:0]  mem_rd_addr,
  output logic [2:0]   mem_rd_size,
  input  logic         mem_rd_rdy,
  input  logic         mem_ret_valid,
  input  logic [127:0] mem_ret_data
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] TAG_MASK = ~((32'd1 << LINE_OFF_W) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA, OWN_UNC} owner_t;

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] starve, starve_nxt;
  logic [2:0]       lat_type, lat_type_nxt;
  logic [31:0]      lat_addr, lat_addr_nxt;
  logic [2:0]       lat_size, lat_size_nxt;

  logic data_haz, unc_haz;
  logic elig_inst, elig_data, elig_unc;
  logic inst_first, gnt_inst;

  // Data-side reads to a line still being written back must wait.
  assign data_haz = wb_pending && (((data_rd_addr ^ wb_addr) & TAG_MASK) == 32'd0);
  assign unc_haz  = wb_pending && (((unc_rd_addr ^ wb_addr) & TAG_MASK) == 32'd0);

  assign elig_inst  = inst_rd_req;
  assign elig_data  = data_rd_req && !data_haz;
  assign elig_unc   = unc_rd_req && !unc_haz;
  assign inst_first = (starve == CNT_W'(STARVE_LIMIT));
  assign gnt_inst   = elig_inst && (inst_first || (!elig_data && !elig_unc));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      owner    <= OWN_NONE;
      starve   <= '0;
      lat_type <= '0;
      lat_addr <= '0;
      lat_size <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      starve   <= starve_nxt;
      lat_type <= lat_type_nxt;
      lat_addr <= lat_addr_nxt;
      lat_size <= lat_size_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    starve_nxt     = starve;
    lat_type_nxt   = lat_type;
    lat_addr_nxt   = lat_addr;
    lat_size_nxt   = lat_size;
    inst_rd_rdy    = 1'b0;
    data_rd_rdy    = 1'b0;
    unc_rd_rdy     = 1'b0;
    inst_ret_valid = 1'b0;
    data_ret_valid = 1'b0;
    unc_ret_valid  = 1'b0;
    mem_rd_req     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (resetn) begin
          if (gnt_inst) begin
            inst_rd_rdy  = 1'b1;
            owner_nxt    = OWN_INST;
            lat_type_nxt = inst_rd_type;
            lat_addr_nxt = inst_rd_addr;
            lat_size_nxt = 3'd2;
            starve_nxt   = '0;
            state_nxt    = S_REQ;
          end else if (elig_data || elig_unc) begin
            if (elig_data) begin
              data_rd_rdy  = 1'b1;
              owner_nxt    = OWN_DATA;
              lat_type_nxt = data_rd_type;
              lat_addr_nxt = data_rd_addr;
              lat_size_nxt = data_rd_size;
            end else begin
              unc_rd_rdy   = 1'b1;
              owner_nxt    = OWN_UNC;
              lat_type_nxt = 3'b010;
              lat_addr_nxt = unc_rd_addr;
              lat_size_nxt = unc_rd_size;
            end
            // Count a lost round for a waiting inst request; saturates at the limit.
            if (inst_rd_req && !inst_first) starve_nxt = starve + CNT_W'(1);
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_rd_req = resetn;
        if (mem_rd_rdy) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        inst_ret_valid = resetn && mem_ret_valid && (owner == OWN_INST);
        data_ret_valid = resetn && mem_ret_valid && (owner == OWN_DATA);
        unc_ret_valid  = resetn && mem_ret_valid && (owner == OWN_UNC);
        if (mem_ret_valid) begin
          state_nxt = S_IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  assign mem_rd_type   = lat_type;
  assign mem_rd_addr   = lat_addr;
  assign mem_rd_size   = lat_size;
  assign inst_ret_data = mem_ret_data;
  assign data_ret_data = mem_ret_data;
  assign unc_ret_data  = mem_ret_data[31:0];

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: queue-free transaction model checked every cycle,
// directed scenarios with literal expectations, and a simple bridge responder.
module tb_cache_rd_arbiter;

  localparam int unsigned LIMIT = 2;
  localparam int unsigned LOFF  = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         inst_rd_req, data_rd_req, unc_rd_req;
  logic [2:0]   inst_rd_type, data_rd_type, data_rd_size, unc_rd_size;
  logic [31:0]  inst_rd_addr, data_rd_addr, unc_rd_addr, wb_addr;
  logic         wb_pending, mem_rd_rdy, mem_ret_valid;
  logic [127:0] mem_ret_data;
  logic         inst_rd_rdy, data_rd_rdy, unc_rd_rdy;
  logic         inst_ret_valid, data_ret_valid, unc_ret_valid;
  logic [127:0] inst_ret_data, data_ret_data;
  logic [31:0]  unc_ret_data;
  logic         mem_rd_req;
  logic [2:0]   mem_rd_type, mem_rd_size;
  logic [31:0]  mem_rd_addr;

  always #5 clk = ~clk;

  cache_rd_arbiter #(.STARVE_LIMIT(LIMIT), .LINE_OFF_W(LOFF)) dut (
    .clk(clk), .resetn(resetn),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_size(data_rd_size), .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
    .data_ret_data(data_ret_data),
    .unc_rd_req(unc_rd_req), .unc_rd_addr(unc_rd_addr), .unc_rd_size(unc_rd_size),
    .unc_rd_rdy(unc_rd_rdy), .unc_ret_valid(unc_ret_valid), .unc_ret_data(unc_ret_data),
    .wb_pending(wb_pending), .wb_addr(wb_addr),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
    .mem_rd_size(mem_rd_size), .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid),
    .mem_ret_data(mem_ret_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: one transaction record plus a count of rounds inst has lost.
  bit          m_busy = 0, m_sent = 0;
  int          m_owner = -1;
  int          m_losses = 0;
  logic [31:0] m_addr = '0;
  logic [2:0]  m_type = '0, m_size = '0;

  function automatic bit hz(input logic [31:0] a);
    return wb_pending && ((a >> LOFF) == (wb_addr >> LOFF));
  endfunction

  // Requester ids: 0 inst, 1 data, 2 unc; -1 nobody.
  function automatic int pick();
    bit el[3];
    int ord[3];
    el[0] = inst_rd_req;
    el[1] = data_rd_req && !hz(data_rd_addr);
    el[2] = unc_rd_req && !hz(unc_rd_addr);
    if (m_losses >= LIMIT) ord = '{0, 1, 2};
    else ord = '{1, 2, 0};
    for (int i = 0; i < 3; i++) if (el[ord[i]]) return ord[i];
    return -1;
  endfunction

  always @(posedge clk) begin : model_upd
    int w;
    if (!resetn) begin
      m_busy = 0; m_sent = 0; m_owner = -1; m_losses = 0;
      m_addr = '0; m_type = '0; m_size = '0;
    end else if (!m_busy) begin
      w = pick();
      if (w >= 0) begin
        m_busy = 1; m_sent = 0; m_owner = w;
        if (w == 0) begin
          m_addr = inst_rd_addr; m_type = inst_rd_type; m_size = 3'd2; m_losses = 0;
        end else begin
          if (w == 1) begin
            m_addr = data_rd_addr; m_type = data_rd_type; m_size = data_rd_size;
          end else begin
            m_addr = unc_rd_addr; m_type = 3'b010; m_size = unc_rd_size;
          end
          if (inst_rd_req && m_losses < LIMIT) m_losses++;
        end
      end
    end else if (!m_sent) begin
      if (mem_rd_rdy) m_sent = 1;
    end else if (mem_ret_valid) begin
      m_busy = 0; m_owner = -1;
    end
  end

  always @(negedge clk) begin : cmp
    int w;
    logic er;
    w  = (resetn && !m_busy) ? pick() : -1;
    er = resetn && m_busy && m_sent && mem_ret_valid;
    chk("inst_rd_rdy", inst_rd_rdy, w == 0);
    chk("data_rd_rdy", data_rd_rdy, w == 1);
    chk("unc_rd_rdy", unc_rd_rdy, w == 2);
    chk("mem_rd_req", mem_rd_req, resetn && m_busy && !m_sent);
    if (resetn && m_busy && !m_sent) begin
      chk("mem_rd_addr", mem_rd_addr, m_addr);
      chk("mem_rd_type", mem_rd_type, m_type);
      chk("mem_rd_size", mem_rd_size, m_size);
    end
    chk("inst_ret_valid", inst_ret_valid, er && m_owner == 0);
    chk("data_ret_valid", data_ret_valid, er && m_owner == 1);
    chk("unc_ret_valid", unc_ret_valid, er && m_owner == 2);
    if (er && m_owner == 0) chk("inst_ret_data", inst_ret_data, mem_ret_data);
    if (er && m_owner == 1) chk("data_ret_data", data_ret_data, mem_ret_data);
    if (er && m_owner == 2) chk("unc_ret_data", unc_ret_data, mem_ret_data[31:0]);
  end

  // Stimulus-side state: grant log, negedge snapshot, bridge responder.
  int          glog[$];
  logic        sn_irdy, sn_drdy, sn_mreq, sn_iret, sn_dret, sn_uret;
  logic [31:0] sn_maddr, sn_idata;
  logic [2:0]  sn_msize;
  bit          br_on = 1, br_wait = 0, keep_d = 0, keep_u = 0, saw_iret = 0;
  int          br_delay = 0, br_cnt = 0, ret_delay = 0, br_rcnt = 0, req_cnt = 0;
  logic [31:0] ret_word = 32'h0;

  task automatic cyc();
    logic s_req, s_rdy, gi, gd, gu;
    @(negedge clk);
    s_req = mem_rd_req; s_rdy = mem_rd_rdy;
    gi = inst_rd_req && inst_rd_rdy;
    gd = data_rd_req && data_rd_rdy;
    gu = unc_rd_req && unc_rd_rdy;
    sn_irdy = inst_rd_rdy; sn_drdy = data_rd_rdy; sn_mreq = mem_rd_req;
    sn_maddr = mem_rd_addr; sn_msize = mem_rd_size;
    sn_iret = inst_ret_valid; sn_dret = data_ret_valid; sn_uret = unc_ret_valid;
    sn_idata = inst_ret_data[31:0];
    if (gi) glog.push_back(0);
    if (gd) glog.push_back(1);
    if (gu) glog.push_back(2);
    if (s_req) req_cnt++;
    if (inst_ret_valid) saw_iret = 1;
    @(posedge clk);
    #1;
    if (gi) inst_rd_req = 0;
    if (gd && !keep_d) data_rd_req = 0;
    if (gu && !keep_u) unc_rd_req = 0;
    if (br_on) begin
      mem_ret_valid = 0;
      if (s_req && s_rdy) begin
        mem_rd_rdy = 0; br_cnt = 0; br_wait = 1; br_rcnt = 0;
      end else if (s_req) begin
        br_cnt++;
        mem_rd_rdy = (br_cnt > br_delay);
      end
      if (br_wait) begin
        if (br_rcnt >= ret_delay) begin
          mem_ret_valid = 1;
          mem_ret_data  = {ret_word + 32'd3, ret_word + 32'd2, ret_word + 32'd1, ret_word};
          br_wait = 0;
          ret_word = ret_word + 32'h100;
        end else br_rcnt++;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_grants(input int n, input int budget);
    for (int i = 0; i < budget && glog.size() < n; i++) cyc();
    chk("grant_count", glog.size(), n);
  endtask

  initial begin
    resetn = 0; wb_pending = 0; wb_addr = '0;
    inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1fc00000;
    data_rd_req = 0; data_rd_type = 3'b100; data_rd_addr = '0; data_rd_size = 3'd2;
    unc_rd_req = 0; unc_rd_addr = '0; unc_rd_size = 3'd2;
    mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_data = '0;

    // Reset with a request pending: nothing may be accepted.
    drain(3);
    chk("rst_inst_rdy", sn_irdy, 1'b0);
    chk("rst_mem_req", sn_mreq, 1'b0);
    inst_rd_req = 0; resetn = 1;
    cyc();
    chk("rst_lat_addr", sn_maddr, 32'h0);

    // Lone inst line read.
    ret_word = 32'hDEADBEEF; glog.delete();
    inst_rd_req = 1;
    cyc();
    chk("t1_inst_rdy", sn_irdy, 1'b1);
    cyc();
    chk("t1_mreq", sn_mreq, 1'b1);
    chk("t1_maddr", sn_maddr, 32'h1fc00000);
    chk("t1_msize", sn_msize, 3'd2);
    drain(2);
    chk("t1_iret", sn_iret, 1'b1);
    chk("t1_idata", sn_idata, 32'hDEADBEEF);
    chk("t1_dret", sn_dret, 1'b0);
    drain(2);

    // All three requesting, each drops after its grant.
    glog.delete();
    inst_rd_addr = 32'h1000; data_rd_addr = 32'h2000; unc_rd_addr = 32'h3000;
    inst_rd_req = 1; data_rd_req = 1; unc_rd_req = 1;
    run_grants(3, 60);
    chk("t2_first", glog[0], 1);
    chk("t2_second", glog[1], 2);
    chk("t2_third", glog[2], 0);
    drain(8);

    // Data and unc never let go: inst wins on the third arbitration.
    glog.delete(); keep_d = 1; keep_u = 1;
    inst_rd_req = 1; data_rd_req = 1; unc_rd_req = 1;
    run_grants(3, 60);
    chk("t3_first", glog[0], 1);
    chk("t3_second", glog[1], 1);
    chk("t3_third", glog[2], 0);
    keep_d = 0; keep_u = 0; data_rd_req = 0; unc_rd_req = 0;
    drain(8);

    // Read-after-writeback hazard on the data side.
    glog.delete();
    wb_pending = 1; wb_addr = 32'h00001230;
    data_rd_addr = 32'h0000123c; data_rd_type = 3'b010; data_rd_req = 1;
    unc_rd_addr = 32'h00002000; unc_rd_req = 1;
    drain(12);
    chk("t4_grants", glog.size(), 1);
    chk("t4_unc_first", glog[0], 2);
    wb_pending = 0;
    cyc();
    chk("t4_data_after_wb", sn_drdy, 1'b1);
    drain(8);

    // Bridge stalls the request; a waiting data read must not be accepted.
    glog.delete(); br_delay = 5; req_cnt = 0; saw_iret = 0;
    inst_rd_addr = 32'h4000; inst_rd_type = 3'b010; inst_rd_req = 1;
    cyc();
    data_rd_addr = 32'h5000; data_rd_type = 3'b100; data_rd_req = 1;
    for (int i = 0; i < 40 && !saw_iret; i++) cyc();
    chk("t5_iret_seen", saw_iret, 1'b1);
    chk("t5_req_cycles", req_cnt, 7);
    chk("t5_no_new_grant", glog.size(), 1);
    drain(12);
    br_delay = 0;

    // Stray bridge return while idle.
    br_on = 0; mem_ret_valid = 1; mem_ret_data = {4{32'h55aa55aa}};
    cyc();
    chk("t6_iret", sn_iret, 1'b0);
    chk("t6_dret", sn_dret, 1'b0);
    chk("t6_uret", sn_uret, 1'b0);
    mem_ret_valid = 0; inst_rd_addr = 32'h6000; inst_rd_req = 1;
    cyc();
    chk("t6_still_idle", sn_irdy, 1'b1);
    br_on = 1;
    drain(8);

    // Reset in WAIT after inst lost one round; counter must restart.
    glog.delete(); ret_delay = 20;
    inst_rd_addr = 32'h7000; inst_rd_req = 1;
    data_rd_addr = 32'h8000; data_rd_req = 1;
    drain(6);
    chk("t7_data_won", glog[0], 1);
    br_on = 0; resetn = 0; mem_ret_valid = 1;
    cyc();
    chk("t7_rst_dret", sn_dret, 1'b0);
    resetn = 1; br_wait = 0; mem_rd_rdy = 0; ret_delay = 0;
    glog.delete(); keep_d = 1; data_rd_req = 1;
    cyc();
    chk("t7_post_dret", sn_dret, 1'b0);
    chk("t7_post_idle", sn_drdy, 1'b1);
    mem_ret_valid = 0; br_on = 1; br_cnt = 0;
    run_grants(3, 60);
    chk("t7_first", glog[0], 1);
    chk("t7_second", glog[1], 1);
    chk("t7_third", glog[2], 0);
    keep_d = 0; data_rd_req = 0;
    drain(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
